// File: rtl/dma_desc_sched.sv
// Descriptor FIFO and launch/retire scheduler in front of the single-channel DMA engine.
// Optional watchdog on the in-flight descriptor: define DMA_SCHED_TMO_EN.
module dma_desc_sched #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
`ifdef DMA_SCHED_TMO_EN
  ,
  parameter int TMO_CYC = 4096
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic        cfg_re,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        dma_en,
  output logic [31:0] dma_src,
  output logic [31:0] dma_dst,
  output logic [31:0] dma_len,
  input  logic        dma_irq,
  output logic        irq,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_RELEASE, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_src, r_dst, r_len;
  logic [31:0]      r_mem_src [DEPTH];
  logic [31:0]      r_mem_dst [DEPTH];
  logic [31:0]      r_mem_len [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr, w_occ;
  logic [CNT_W-1:0] r_donecnt;
  logic [31:0]      r_dma_src, r_dma_dst, r_dma_len, w_status;
  logic             r_irq, r_err_len, r_err_ovf;
  logic             w_full, w_empty, w_cmd, w_push, w_push_ok, w_clr;
  logic             w_launch, w_pop, w_done_inc;
  logic             w_tmo, w_tmo_hit, w_err_tmo;

  assign w_occ     = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_cmd     = cfg_we && (cfg_addr == 5'h0C);
  assign w_push    = w_cmd && cfg_wdata[0];
  assign w_clr     = w_cmd && cfg_wdata[1];
  // Full is judged before any pop on the same edge, so a full queue always rejects.
  assign w_push_ok = w_push && (r_len != '0) && !w_full;
  assign w_launch  = (r_state == S_IDLE) && !w_empty;

`ifdef DMA_SCHED_TMO_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo_hit, r_err_tmo;

  assign w_tmo     = (r_state == S_WAIT_DONE) && !dma_irq && (r_tmo_cnt == TW'(TMO_CYC - 1));
  assign w_tmo_hit = r_tmo_hit;
  assign w_err_tmo = r_err_tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
      r_tmo_hit <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == S_WAIT_DONE) ? r_tmo_cnt + 1'b1 : '0;
      if (w_launch)   r_tmo_hit <= 1'b0;
      else if (w_tmo) r_tmo_hit <= 1'b1;
      if (w_clr) r_err_tmo <= 1'b0;
      if (w_tmo) r_err_tmo <= 1'b1;
    end
  end
`else
  assign w_tmo     = 1'b0;
  assign w_tmo_hit = 1'b0;
  assign w_err_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done_inc  = 1'b0;
    unique case (r_state)
      S_IDLE:      if (!w_empty) w_state_nxt = S_LAUNCH;
      S_LAUNCH:    w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (dma_irq) begin
          w_state_nxt = S_RELEASE;
        end else if (w_tmo) begin
          w_state_nxt = S_RELEASE;
          w_pop       = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!dma_irq) begin
          w_state_nxt = S_GAP;
          w_pop       = !w_tmo_hit;
          w_done_inc  = !w_tmo_hit;
        end
      end
      S_GAP:       w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the descriptor store has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_src[r_wr_ptr[AW-1:0]] <= r_src;
      r_mem_dst[r_wr_ptr[AW-1:0]] <= r_dst;
      r_mem_len[r_wr_ptr[AW-1:0]] <= r_len;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments win within a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_donecnt <= '0;
      r_dma_src <= '0;
      r_dma_dst <= '0;
      r_dma_len <= '0;
      r_irq     <= 1'b0;
      r_err_len <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      if (cfg_we && cfg_addr == 5'h00) r_src <= cfg_wdata;
      if (cfg_we && cfg_addr == 5'h04) r_dst <= cfg_wdata;
      if (cfg_we && cfg_addr == 5'h08) r_len <= cfg_wdata;
      if (w_push_ok)  r_wr_ptr  <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr  <= r_rd_ptr + 1'b1;
      if (w_done_inc) r_donecnt <= r_donecnt + 1'b1;
      if (w_launch) begin
        r_dma_src <= r_mem_src[r_rd_ptr[AW-1:0]];
        r_dma_dst <= r_mem_dst[r_rd_ptr[AW-1:0]];
        r_dma_len <= r_mem_len[r_rd_ptr[AW-1:0]];
      end
      // Clear first, then set: errors raised by a push or retire on this edge survive CLR.
      if (w_clr) begin
        r_irq     <= 1'b0;
        r_err_len <= 1'b0;
        r_err_ovf <= 1'b0;
      end
      if (w_push && r_len == '0) r_err_len <= 1'b1;
      if (w_push && w_full)      r_err_ovf <= 1'b1;
      if (w_pop && w_occ == OCC_ONE && !w_push_ok) r_irq <= 1'b1;
    end
  end

  assign dma_en  = (r_state == S_LAUNCH) || (r_state == S_WAIT_DONE);
  assign busy    = dma_en || (r_state == S_RELEASE);
  assign irq     = r_irq;
  assign dma_src = r_dma_src;
  assign dma_dst = r_dma_dst;
  assign dma_len = r_dma_len;

  always_comb begin
    w_status       = '0;
    w_status[0]    = busy;
    w_status[1]    = w_full;
    w_status[2]    = w_empty;
    w_status[3]    = r_irq;
    w_status[4]    = r_err_len;
    w_status[5]    = r_err_ovf;
    w_status[6]    = w_err_tmo;
    w_status[11:8] = 4'(w_occ);
    cfg_rdata      = '0;
    if (cfg_re) begin
      case (cfg_addr)
        5'h00:   cfg_rdata = r_src;
        5'h04:   cfg_rdata = r_dst;
        5'h08:   cfg_rdata = r_len;
        5'h10:   cfg_rdata = w_status;
        5'h14:   cfg_rdata = 32'(r_donecnt);
        default: cfg_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_desc_sched.sv
// Randomized bench for dma_desc_sched: a queue-based model of the descriptor scheduler
// plus directed scenarios for fill, zero length, drain-with-push, reset and timeout.
module tb_dma_desc_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, cfg_re;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        dma_en, dma_irq, irq, busy;
  logic [31:0] dma_src, dma_dst, dma_len;

  always #5 clk = ~clk;

  dma_desc_sched #(
    .DEPTH(DEPTH),
    .CNT_W(16)
`ifdef DMA_SCHED_TMO_EN
    ,
    .TMO_CYC(64)
`endif
  ) u_dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .dma_en(dma_en), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .dma_irq(dma_irq), .irq(irq), .busy(busy)
  );

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
  } desc_t;

  desc_t       m_q[$];
  logic [31:0] m_src, m_dst, m_len;
  bit          m_irq, m_err_len, m_err_ovf, m_err_tmo;
  int unsigned m_donecnt;
  int          n_vec = 0, n_bad = 0;
  int          en_run = 0, low_run = 0, n_hi;
  bit          seen_high = 1'b0;
  int          act;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_src = '0; m_dst = '0; m_len = '0;
    m_irq = 1'b0; m_err_len = 1'b0; m_err_ovf = 1'b0; m_err_tmo = 1'b0;
    m_donecnt = 0;
  endtask

  task automatic m_write(input logic [4:0] a, input logic [31:0] d);
    bit e_len, e_ovf;
    case (a)
      5'h00: m_src = d;
      5'h04: m_dst = d;
      5'h08: m_len = d;
      5'h0C: begin
        e_len = d[0] && (m_len == 32'h0);
        e_ovf = d[0] && (m_q.size() == DEPTH);
        if (d[0] && !e_len && !e_ovf) m_q.push_back('{m_src, m_dst, m_len});
        if (d[1]) begin
          m_irq = 1'b0; m_err_len = 1'b0; m_err_ovf = 1'b0; m_err_tmo = 1'b0;
        end
        if (e_len) m_err_len = 1'b1;
        if (e_ovf) m_err_ovf = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic m_retire(input bit counted);
    void'(m_q.pop_front());
    if (counted) m_donecnt++;
    if (m_q.size() == 0) m_irq = 1'b1;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (m_q.size() != 0);
    s[1]     = (m_q.size() == DEPTH);
    s[2]     = (m_q.size() == 0);
    s[3]     = m_irq;
    s[4]     = m_err_len;
    s[5]     = m_err_ovf;
    s[6]     = m_err_tmo;
    s[11:8]  = 4'(m_q.size());
    return s;
  endfunction

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk);
    m_write(a, d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
    cfg_re = 1'b1; cfg_addr = a;
    #1;
    d = cfg_rdata;
    cfg_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cfg_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic check_all(input string tag);
    check_reg({tag, "_status"}, 5'h10, m_status());
    check_reg({tag, "_donecnt"}, 5'h14, {16'h0, m_donecnt[15:0]});
    check({tag, "_en"}, 32'(dma_en), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check({tag, "_src"}, dma_src, m_q[0].src);
      check({tag, "_dst"}, dma_dst, m_q[0].dst);
      check({tag, "_len"}, dma_len, m_q[0].len);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    cfg_write(5'h00, s);
    cfg_write(5'h04, d);
    cfg_write(5'h08, l);
    cfg_write(5'h0C, 32'h1);
  endtask

  // Plays the DMA for the head descriptor: completion pulse, optional CMD on the retire edge,
  // optional stale completion during the GAP cycle.
  task automatic service(input int wait_cyc, input bit with_push, input logic [31:0] cmd,
                         input bit stale);
    repeat (wait_cyc) @(negedge clk);
    check("svc_en", 32'(dma_en), 32'h1);
    check("svc_src", dma_src, m_q[0].src);
    check("svc_dst", dma_dst, m_q[0].dst);
    check("svc_len", dma_len, m_q[0].len);
    dma_irq = 1'b1;
    @(negedge clk);
    check("rel_en", 32'(dma_en), 32'h0);
    check("rel_busy", 32'(busy), 32'h1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    dma_irq = 1'b0;
    if (with_push) begin
      cfg_we = 1'b1; cfg_addr = 5'h0C; cfg_wdata = cmd;
    end
    @(posedge clk);
    if (with_push) m_write(5'h0C, cmd);
    m_retire(1'b1);
    @(negedge clk);
    cfg_we = 1'b0;
    check("gap_en", 32'(dma_en), 32'h0);
    if (stale) begin
      dma_irq = 1'b1;
      @(negedge clk);
      dma_irq = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (dma_en === 1'b1) begin
      if (seen_high && low_run > 0) check("en_low_gap", 32'(low_run >= 2), 32'h1);
      en_run++;
      low_run   = 0;
      seen_high = 1'b1;
    end else begin
      en_run = 0;
      low_run++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0; dma_irq = 1'b0;
    m_reset();
    settle(3);
    check("rst_en", 32'(dma_en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_src", dma_src, 32'h0);
    check("rst_len", dma_len, 32'h0);
    check("rdata_idle", cfg_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_all("reset");
    check_reg("reset_status_c", 5'h10, 32'h4);
    check_reg("reset_stg_src", 5'h00, 32'h0);

    // Single descriptor
    cfg_write(5'h00, 32'h1000);
    cfg_write(5'h04, 32'h2000);
    cfg_write(5'h08, 32'd16);
    cfg_write(5'h0C, 32'h1);
    check("single_en_c1", 32'(dma_en), 32'h0);
    @(negedge clk);
    check("single_en_c2", 32'(dma_en), 32'h1);
    check("single_src", dma_src, 32'h1000);
    check("single_dst", dma_dst, 32'h2000);
    check("single_len", dma_len, 32'd16);
    service(40, 1'b0, 32'h0, 1'b0);
    settle(4);
    check_reg("single_donecnt_c", 5'h14, 32'h1);
    check_reg("single_status_c", 5'h10, 32'h0C);
    check_all("single");
    cfg_write(5'h0C, 32'h2);
    check_all("clr1");

    // Queue fill: fifth push is rejected
    for (int i = 0; i < DEPTH + 1; i++)
      push_desc(32'hA000_0000 + i, 32'hB000_0000 + i, 32'(i + 1));
    check_all("fill");
    check_reg("fill_status_c", 5'h10, 32'h0000_0423);
    for (int i = 0; i < DEPTH; i++) begin
      service(2, 1'b0, 32'h0, 1'b0);
      settle(4);
      check_all("drain");
    end
    check("drain_irq_pin", 32'(irq), 32'h1);
    cfg_write(5'h0C, 32'h2);

    // Zero-length push
    cfg_write(5'h08, 32'h0);
    cfg_write(5'h0C, 32'h1);
    settle(3);
    check("len0_en", 32'(dma_en), 32'h0);
    check_reg("len0_status_c", 5'h10, 32'h14);
    check_all("len0");
    cfg_write(5'h0C, 32'h2);
    check_reg("len0_clr_c", 5'h10, 32'h4);

    // Push on the retire edge with two entries queued
    push_desc(32'h11, 32'h21, 32'h31);
    push_desc(32'h12, 32'h22, 32'h32);
    settle(3);
    check_all("pwd_pre");
    cfg_write(5'h00, 32'h13);
    cfg_write(5'h04, 32'h23);
    cfg_write(5'h08, 32'h33);
    service(1, 1'b1, 32'h1, 1'b0);
    settle(4);
    check_reg("pwd_status_c", 5'h10, 32'h0000_0201);
    check("pwd_head_c", dma_src, 32'h12);
    check_all("pwd");
    service(0, 1'b0, 32'h0, 1'b0);
    settle(4);
    service(0, 1'b0, 32'h0, 1'b0);
    settle(4);
    check_all("pwd_done");

    // Reset in WAIT_DONE
    push_desc(32'h55, 32'h66, 32'h77);
    settle(3);
    check("rmid_en_pre", 32'(dma_en), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rmid_en_async", 32'(dma_en), 32'h0);
    check("rmid_busy", 32'(busy), 32'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reg("rmid_status_c", 5'h10, 32'h4);
    settle(8);
    check("rmid_no_launch", 32'(dma_en), 32'h0);
    check_all("rmid");

`ifdef DMA_SCHED_TMO_EN
    // Watchdog: no completion ever arrives
    push_desc(32'h99, 32'h98, 32'h97);
    n_hi = 0;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      if (dma_en) n_hi++;
      else if (n_hi > 0) break;
    end
    check("tmo_en_cycles", 32'(n_hi), 32'd65);
    m_retire(1'b0);
    m_err_tmo = 1'b1;
    settle(4);
    check_reg("tmo_status_c", 5'h10, 32'h4C);
    check_all("tmo");
    cfg_write(5'h0C, 32'h2);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      act = int'($urandom_range(0, 9));
      if (m_q.size() != 0 && en_run > 30) act = 9;
      case (act)
        0: cfg_write(5'h00, $urandom);
        1: cfg_write(5'h04, $urandom);
        2: cfg_write(5'h08, ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom);
        3, 4: cfg_write(5'h0C, ($urandom_range(0, 5) == 0) ? 32'h3 : 32'h1);
        5: cfg_write(5'h0C, 32'h2);
        6: begin
          check_reg("rnd_stg_src", 5'h00, m_src);
          check_reg("rnd_stg_dst", 5'h04, m_dst);
          check_reg("rnd_stg_len", 5'h08, m_len);
          check_reg("rnd_cmd_rd", 5'h0C, 32'h0);
        end
        7: begin
          if (m_q.size() == 0) begin
            dma_irq = 1'b1;
            settle(2);
            dma_irq = 1'b0;
          end else begin
            service(0, 1'b0, 32'h0, 1'b1);
          end
        end
        default: begin
          if (m_q.size() != 0)
            service(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 32'h3 : 32'h1, bit'($urandom_range(0, 1)));
          else
            cfg_write(5'h0C, 32'h1);
        end
      endcase
      settle(4);
      check_all("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
